halfbridge_pwm: RTL
===================

Name: halfbridge_pwm

Overview:
- Downstream stage of the sine LUT generator. Consumes its 8-bit positive/negative half-wave samples and drives a two-leg PWM (H-bridge style) audio output.
- Latches one sample pair per PWM period and applies a volume attenuation shift.
- Guarantees the two legs are never high together, and inserts dead-time on every polarity change.
- Emits a one-cycle period_start pulse that is wired to the generator's sin_clk, so exactly one sample is consumed per PWM period.

Parameters:
- CNT_W, 8, PWM counter width; period = 2**CNT_W clk cycles; equals sample width.
- DEAD_CYCLES, 2, leading cycles forced low on both legs after a polarity change; legal range 0..2**CNT_W-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  run/stop; low holds the block idle with outputs low.
- pos_in  in  CNT_W  positive half-wave sample (0 when the generator is in the negative half).
- neg_in  in  CNT_W  negative half-wave sample (0 when the generator is in the positive half).
- atten  in  3  volume; duty = sample >> atten.
- pwm_pos  out  1  positive-leg drive, registered.
- pwm_neg  out  1  negative-leg drive, registered.
- period_start  out  1  one-cycle pulse when a new period begins; feeds sin_clk.
- conflict  out  1  sticky flag: pos_in and neg_in were both nonzero at a latch.

Behaviour:
- Reset, and every idle cycle: cnt=MAX (2**CNT_W-1), duty_pos=duty_neg=0, side=NONE, last_side=NONE, pwm_pos=pwm_neg=0, period_start=0. conflict clears on reset only.
- Counter:
  - While enable=1, cnt increments each clk and wraps MAX->0.
  - Any clk edge sampling enable=0 sets cnt=MAX and clears duty, side and last_side. pwm_pos/pwm_neg go low on that same edge.
- Latch event: an edge where enable=1 and cnt==MAX. It captures:
  - duty_pos = pos_in >> atten, duty_neg = neg_in >> atten;
  - side = POS if duty_pos != 0, else NEG if duty_neg != 0, else NONE.
  - First period after enable rises: the latch occurs on the first enabled edge, and cnt=0 follows.
- Conflict: if pos_in != 0 and neg_in != 0 at a latch, POS wins, duty_neg is forced to 0 and conflict is set (sticky).
- Dead-time: at a latch, dead=1 if side is POS or NEG, last_side is not NONE, and side != last_side; otherwise dead=0. After evaluation, last_side <= side only when side != NONE.
- dead_lim = dead ? DEAD_CYCLES : 0.
- Outputs, registered (one-cycle latency from cnt):
  - pwm_pos <= enable && side==POS && cnt >= dead_lim && cnt < duty_pos;
  - pwm_neg <= enable && side==NEG && cnt >= dead_lim && cnt < duty_neg.
- High time per period = max(0, duty - dead_lim) cycles. duty <= dead_lim gives a fully low period. Max duty MAX gives MAX/2**CNT_W.
- period_start is high exactly while cnt==0 and enable=1; one pulse per 2**CNT_W cycles.
- pwm_pos && pwm_neg is never 1 in any cycle (invariant, assert).
- Reset or enable drop mid-period: outputs low the next cycle; no partial pulse resumes.

Decomposition:
- Package sg_pkg:
  - side_t enum {SIDE_NONE, SIDE_POS, SIDE_NEG};
  - SAMPLE_W=8 constant, shared with the sine generator;
  - ATTEN_W=3.
- Sub-module pwm_period_ctr: cnt register, wrap, idle-at-MAX, latch strobe and period_start decode.
- Top level holds the latch, side/dead logic and output flops.

Test Plan:
1. Reset, enable=1, pos_in=128, neg_in=0, atten=0 -> period_start every 256 cycles; pwm_pos high exactly 128 consecutive cycles per period; pwm_neg=0; conflict=0.
2. Period A pos_in=100, period B neg_in=100, DEAD_CYCLES=2 -> B: pwm_neg high 98 cycles starting 2 cycles late; pwm_pos=0. Period C neg_in=100 again -> 100 cycles, no dead-time.
3. Polarity switch with neg_in=2 after a POS period -> pwm_neg low all period; the next NEG period gets no dead-time (last_side already NEG).
4. pos_in=255, atten=3 -> duty 31, pwm_pos high 31 cycles; atten=7 -> duty 1, high 1 cycle.
5. pos_in=10 and neg_in=10 at latch -> pwm_pos 10 cycles, pwm_neg 0, conflict=1 and stays 1 through later clean periods until reset.
6. Drop enable at cnt=50 with pwm_pos high -> both legs low next cycle, period_start silent. Re-enable -> latch on the first edge, period_start the cycle after. Repeat using reset -> same, conflict cleared.

Source files
------------

// File: rtl/sg_pkg.sv
// Types and constants shared by the sine generator and the half-bridge PWM stage.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package sg_pkg;

  // Sample width is common to the generator and the PWM counter.
  localparam int SAMPLE_W = 8;
  localparam int ATTEN_W  = 3;

  // Which leg the current period drives.
  typedef enum logic [1:0] {
    SIDE_NONE = 2'd0,
    SIDE_POS  = 2'd1,
    SIDE_NEG  = 2'd2
  } side_t;

endpackage

// File: rtl/pwm_period_ctr.sv
// PWM period counter: free-running while enabled, parked at MAX when idle; decodes latch and period_start.
// Latency: cnt is registered; latch and period_start are combinational from cnt and enable.
// Backpressure: none; enable low parks the counter at MAX so the first enabled edge latches.
module pwm_period_ctr
  import sg_pkg::*;
#(
  parameter int CNT_W = SAMPLE_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] cnt,
  output logic             latch,
  output logic             period_start
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Count up while enabled (natural wrap MAX->0); reset or idle parks at MAX.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt <= CNT_MAX;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // The last count of a period is the edge that captures the next sample pair.
  assign latch        = enable && (cnt == CNT_MAX);
  assign period_start = enable && (cnt == '0);

endmodule

// File: rtl/halfbridge_pwm.sv
// Two-leg PWM driver: latches one attenuated sample pair per period, never drives both legs, adds dead-time on polarity change.
// Latency: pwm outputs registered one cycle behind the counter; first high cycle one cycle after period_start.
// Backpressure: none; period_start paces the upstream generator to one sample per period, enable low idles with outputs low.
module halfbridge_pwm
  import sg_pkg::*;
#(
  parameter int CNT_W       = SAMPLE_W,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [CNT_W-1:0]   pos_in,
  input  logic [CNT_W-1:0]   neg_in,
  input  logic [ATTEN_W-1:0] atten,
  output logic               pwm_pos,
  output logic               pwm_neg,
  output logic               period_start,
  output logic               conflict
);

  localparam logic [CNT_W-1:0] DEAD_LIM = CNT_W'(DEAD_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic             latch;
  logic [CNT_W-1:0] duty_pos, duty_neg;
  side_t            side, last_side;
  logic             dead;

  logic [CNT_W-1:0] duty_pos_nxt, duty_neg_nxt, dead_lim;
  side_t            side_nxt;
  logic             dead_nxt, both_nz;

  pwm_period_ctr #(.CNT_W(CNT_W)) u_ctr (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cnt          (cnt),
    .latch        (latch),
    .period_start (period_start)
  );

  // Decode the sample pair into duties and a side; positive wins when both are nonzero.
  always_comb begin
    duty_pos_nxt = pos_in >> atten;
    duty_neg_nxt = neg_in >> atten;
    both_nz      = (pos_in != '0) && (neg_in != '0);
    side_nxt     = SIDE_NONE;
    dead_nxt     = 1'b0;
    if (both_nz) begin
      duty_neg_nxt = '0;
    end
    if (duty_pos_nxt != '0) begin
      side_nxt = SIDE_POS;
    end else if (duty_neg_nxt != '0) begin
      side_nxt = SIDE_NEG;
    end
    // Dead-time only on a real swap between legs; silent periods do not count as a swap.
    if (side_nxt != SIDE_NONE && last_side != SIDE_NONE && side_nxt != last_side) begin
      dead_nxt = 1'b1;
    end
  end

  assign dead_lim = dead ? DEAD_LIM : '0;

  // Per-period state: captured on the latch edge, cleared when idle; conflict is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      duty_pos  <= '0;
      duty_neg  <= '0;
      side      <= SIDE_NONE;
      last_side <= SIDE_NONE;
      dead      <= 1'b0;
      conflict  <= 1'b0;
    end else if (!enable) begin
      duty_pos  <= '0;
      duty_neg  <= '0;
      side      <= SIDE_NONE;
      last_side <= SIDE_NONE;
      dead      <= 1'b0;
    end else if (latch) begin
      duty_pos <= duty_pos_nxt;
      duty_neg <= duty_neg_nxt;
      side     <= side_nxt;
      dead     <= dead_nxt;
      if (side_nxt != SIDE_NONE) begin
        last_side <= side_nxt;
      end
      if (both_nz) begin
        conflict <= 1'b1;
      end
    end
  end

  // Output flops: the side gate makes the two legs mutually exclusive by construction.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      pwm_pos <= 1'b0;
      pwm_neg <= 1'b0;
    end else begin
      pwm_pos <= (side == SIDE_POS) && (cnt >= dead_lim) && (cnt < duty_pos);
      pwm_neg <= (side == SIDE_NEG) && (cnt >= dead_lim) && (cnt < duty_neg);
    end
  end

  legs_exclusive: assert property (@(posedge clk) !(pwm_pos && pwm_neg));

endmodule
